// File: rtl/syn_tb_pkg.sv
// Shared definitions for the synthetic traffic bench throttles.
package syn_tb_pkg;

   // Full-scale percentage used when a throttle does not override it.
   localparam int unsigned DENOM_DEF = 100;

   // Queue-index width shared with the traffic generators.
   localparam int unsigned LOG2_Q = 2;
   typedef logic [LOG2_Q-1:0] ch_idx_t;

   // Width at which saturation is evaluated; wide enough for any accumulator sum.
   localparam int unsigned SAT_W = 64;

   // Clamp a signed value into the signed range of a w-bit register.
   function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] v,
                                                     input int unsigned w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/throttle_acc.sv
// One Bresenham credit accumulator: init from perc, grant/deny update, saturation, reload.
module throttle_acc
   import syn_tb_pkg::*;
#(
   parameter int unsigned PERC_W = 8,
   parameter int unsigned LEN_W  = 4,
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned DENOM  = DENOM_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PERC_W-1:0] perc,
   input  logic              reload,
   input  logic              upd,
   input  logic [LEN_W-1:0]  len,
   output logic              pos
);

   localparam int unsigned CW = ACC_W + LEN_W + 2;
   localparam logic signed [CW-1:0] DEN_W = CW'(DENOM);

   logic signed [CW-1:0]    perc_w;
   logic signed [CW-1:0]    p_w;
   logic signed [CW-1:0]    init_w;
   logic signed [CW-1:0]    step_w;
   logic signed [CW-1:0]    sum_w;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;

   // Positive credit means the next evaluation of this channel grants.
   assign pos = !acc_q[ACC_W-1] && (acc_q != '0);

   // Clamp the percentage, derive init and the grant/deny step, saturate the sum.
   always_comb begin
      perc_w = signed'(CW'(perc));
      p_w    = (perc_w > DEN_W) ? DEN_W : perc_w;
      init_w = (p_w <<< 1) - DEN_W;
      if (pos) step_w = ((p_w - DEN_W) <<< 1) * signed'(CW'(len));
      else     step_w = p_w <<< 1;
      sum_w  = CW'(acc_q) + step_w;
      acc_d  = acc_q;
      if (reload)   acc_d = ACC_W'(init_w);
      else if (upd) acc_d = ACC_W'(sat_s(SAT_W'(sum_w), ACC_W));
   end

   // Accumulator register; reset reinitialises from the current percentage.
   always_ff @(posedge clk) begin
      if (reset) acc_q <= ACC_W'(init_w);
      else       acc_q <= acc_d;
   end

endmodule

// File: rtl/throttle_mc.sv
// Multi-channel bandwidth throttle: id decode, grant register, bypass and grant counters.
module throttle_mc
   import syn_tb_pkg::*;
#(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned LOG2_CH = 2,
   parameter int unsigned PERC_W  = 8,
   parameter int unsigned LEN_W   = 4,
   parameter int unsigned ACC_W   = 16,
   parameter int unsigned DENOM   = DENOM_DEF,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     bypass,
   input  logic [NUM_CH*PERC_W-1:0] perc,
   input  logic [NUM_CH-1:0]        reload,
   input  logic                     valid,
   input  logic [LOG2_CH-1:0]       id,
   input  logic [LEN_W-1:0]         len,
   output logic                     ready,
   output logic [LOG2_CH-1:0]       ready_id,
   output logic [NUM_CH*CNT_W-1:0]  grant_cnt
);

   logic [NUM_CH-1:0]  sel;
   logic [NUM_CH-1:0]  pos;
   logic [NUM_CH-1:0]  upd;
   logic               eval;
   logic               grant;
   logic               ready_q;
   logic [LOG2_CH-1:0] ready_id_q;
   logic [CNT_W-1:0]   cnt_q [NUM_CH];

   // One-hot decode doubles as the id range check: an out-of-range id selects nothing.
   assign eval  = valid && !ready_q && (|sel);
   // A reload on the evaluated channel forces a deny, even in bypass.
   assign grant = eval && !(|(sel & reload)) && (bypass || (|(sel & pos)));

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign sel[c] = (id == LOG2_CH'(c));
      assign upd[c] = eval && sel[c] && !bypass;
      assign grant_cnt[c*CNT_W +: CNT_W] = cnt_q[c];

      throttle_acc #(
         .PERC_W (PERC_W),
         .LEN_W  (LEN_W),
         .ACC_W  (ACC_W),
         .DENOM  (DENOM)
      ) u_acc (
         .clk    (clk),
         .reset  (reset),
         .perc   (perc[c*PERC_W +: PERC_W]),
         .reload (reload[c]),
         .upd    (upd[c]),
         .len    (len),
         .pos    (pos[c])
      );
   end

   assign ready    = ready_q;
   assign ready_id = ready_id_q;

   // Grant pulse, granted channel and per-channel wrapping grant counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q    <= 1'b0;
         ready_id_q <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      end else begin
         ready_q <= grant;
         if (grant) ready_id_q <= id;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant && sel[c]) cnt_q[c] <= cnt_q[c] + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_throttle_mc.sv
// Scoreboard bench for throttle_mc: a per-cycle behavioural model pushes expectations.
module tb_throttle_mc;

   localparam int NUM_CH  = 4;
   localparam int LOG2_CH = 2;
   localparam int PERC_W  = 8;
   localparam int LEN_W   = 4;
   localparam int ACC_W   = 8;
   localparam int DENOM   = 100;
   localparam int CNT_W   = 16;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     bypass;
   logic [NUM_CH*PERC_W-1:0] perc;
   logic [NUM_CH-1:0]        reload;
   logic                     valid;
   logic [LOG2_CH-1:0]       id;
   logic [LEN_W-1:0]         len;
   logic                     ready;
   logic [LOG2_CH-1:0]       ready_id;
   logic [NUM_CH*CNT_W-1:0]  grant_cnt;

   always #5 clk = ~clk;

   throttle_mc #(
      .NUM_CH  (NUM_CH),
      .LOG2_CH (LOG2_CH),
      .PERC_W  (PERC_W),
      .LEN_W   (LEN_W),
      .ACC_W   (ACC_W),
      .DENOM   (DENOM),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bypass    (bypass),
      .perc      (perc),
      .reload    (reload),
      .valid     (valid),
      .id        (id),
      .len       (len),
      .ready     (ready),
      .ready_id  (ready_id),
      .grant_cnt (grant_cnt)
   );

   typedef struct packed {
      logic                   rdy;
      logic                   rst;
      logic [LOG2_CH-1:0]     rid;
      logic [3:0][CNT_W-1:0]  cnt;
      logic [3:0][ACC_W-1:0]  acc;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   d_m   [NUM_CH];
   int   cnt_m [NUM_CH];
   bit   rdy_m = 1'b0;
   int   rid_m = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic int pe(input int c);
      int p;
      p = int'(perc[c*PERC_W +: PERC_W]);
      return (p > DENOM) ? DENOM : p;
   endfunction

   function automatic int sat(input int v);
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic logic [31:0] obs_acc(input int c);
      logic [ACC_W-1:0] a;
      case (c)
         0:       a = dut.g_ch[0].u_acc.acc_q;
         1:       a = dut.g_ch[1].u_acc.acc_q;
         2:       a = dut.g_ch[2].u_acc.acc_q;
         default: a = dut.g_ch[3].u_acc.acc_q;
      endcase
      return {24'b0, a};
   endfunction

   // Advance the model one clock from the current inputs, then compare after the edge.
   task automatic step();
      exp_t e;
      int   c;
      if (reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            d_m[k]   = 2 * pe(k) - DENOM;
            cnt_m[k] = 0;
         end
         rdy_m = 1'b0;
         rid_m = 0;
      end else begin
         if (rdy_m) begin
            rdy_m = 1'b0;
         end else if (valid) begin
            c = int'(id);
            if (reload[c]) begin
               rdy_m = 1'b0;
            end else if (bypass) begin
               rdy_m = 1'b1;
            end else if (d_m[c] > 0) begin
               d_m[c] = sat(d_m[c] + (2 * pe(c) - 2 * DENOM) * int'(len));
               rdy_m  = 1'b1;
            end else begin
               d_m[c] = sat(d_m[c] + 2 * pe(c));
               rdy_m  = 1'b0;
            end
            if (rdy_m) begin
               rid_m    = c;
               cnt_m[c] = (cnt_m[c] + 1) & 16'hFFFF;
            end
         end
         for (int k = 0; k < NUM_CH; k++)
            if (reload[k]) d_m[k] = 2 * pe(k) - DENOM;
      end
      e.rdy = rdy_m;
      e.rst = reset;
      e.rid = LOG2_CH'(rid_m);
      for (int k = 0; k < NUM_CH; k++) begin
         e.cnt[k] = CNT_W'(cnt_m[k]);
         e.acc[k] = ACC_W'(d_m[k]);
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      check("ready", {31'b0, ready}, {31'b0, e.rdy});
      if (e.rdy || e.rst) check("ready_id", {30'b0, ready_id}, {30'b0, e.rid});
      for (int k = 0; k < NUM_CH; k++) begin
         check($sformatf("cnt%0d", k), {16'b0, grant_cnt[k*CNT_W +: CNT_W]}, {16'b0, e.cnt[k]});
         check($sformatf("acc%0d", k), obs_acc(k), {24'b0, e.acc[k]});
      end
   endtask

   // Hold a request on channel ch until n evaluations have happened, then flush.
   task automatic run_evals(input int ch, input int l, input int n);
      int ev;
      int guard;
      ev    = 0;
      guard = 0;
      valid = 1'b1;
      id    = LOG2_CH'(ch);
      len   = LEN_W'(l);
      while (ev < n && guard < 4 * n + 8) begin
         if (!rdy_m) ev++;
         step();
         guard++;
      end
      if (ev < n) check("eval_budget", ev, n);
      valid = 1'b0;
      step();
   endtask

   task automatic do_reload(input logic [NUM_CH-1:0] m);
      reload = m;
      step();
      reload = '0;
   endtask

   function automatic logic [31:0] cnt_of(input int c);
      return {16'b0, grant_cnt[c*CNT_W +: CNT_W]};
   endfunction

   initial begin
      int guard;
      reset  = 1'b1;
      bypass = 1'b0;
      perc   = {4{8'd50}};
      reload = '0;
      valid  = 1'b0;
      id     = '0;
      len    = 4'd1;
      repeat (3) step();
      check("rst_ready", {31'b0, ready}, 32'd0);
      check("rst_acc0", obs_acc(0), 32'd0);
      reset = 1'b0;

      // 50 % pacing: first evaluation denies from d0=0, then alternates.
      run_evals(0, 1, 40);
      check("cnt0_50pct", cnt_of(0), 32'd20);

      // Extremes and clamping.
      perc[7:0] = 8'd100; do_reload(4'b0001);
      run_evals(0, 1, 10);
      check("cnt0_p100", cnt_of(0), 32'd30);
      perc[7:0] = 8'd0;   do_reload(4'b0001);
      run_evals(0, 1, 50);
      check("cnt0_p0", cnt_of(0), 32'd30);
      perc[7:0] = 8'd200; do_reload(4'b0001);
      run_evals(0, 3, 10);
      check("cnt0_p200", cnt_of(0), 32'd40);
      // Percentage change without reload takes effect at the next evaluation.
      perc[7:0] = 8'd50;
      run_evals(0, 1, 4);

      // Channel independence.
      perc[15:8] = 8'd100; perc[23:16] = 8'd0; do_reload(4'b0110);
      for (int i = 0; i < 10; i++) begin
         run_evals(1, 2, 1);
         run_evals(2, 3, 1);
      end
      check("cnt1_indep", cnt_of(1), 32'd10);
      check("cnt2_indep", cnt_of(2), 32'd0);

      // Saturation with a heavy burst weight on a low percentage.
      perc[31:24] = 8'd10; do_reload(4'b1000);
      run_evals(3, 15, 40);

      // Bypass: perc=0 channel grants on every evaluation, accumulator untouched.
      bypass = 1'b1;
      run_evals(2, 1, 10);
      bypass = 1'b0;
      check("cnt2_bypass", cnt_of(2), 32'd10);
      check("acc2_bypass", obs_acc(2), 32'h9C);

      // Reload coinciding with an evaluation of the same channel.
      do_reload(4'b0001);
      run_evals(0, 1, 1);
      valid  = 1'b1;
      id     = 2'd0;
      reload = 4'b0001;
      step();
      reload = '0;
      valid  = 1'b0;
      step();
      check("acc0_reload", obs_acc(0), 32'd0);

      // Reset asserted during a ready pulse.
      perc[15:8] = 8'd100;
      valid = 1'b1;
      id    = 2'd1;
      len   = 4'd1;
      guard = 0;
      while (!rdy_m && guard < 6) begin
         step();
         guard++;
      end
      check("pre_rst_ready", {31'b0, ready}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      valid = 1'b0;
      step();
      check("cnt1_after_rst", cnt_of(1), 32'd0);
      check("acc3_after_rst", obs_acc(3), 32'hB0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/throttle_mc.md
# throttle_mc

Multi-channel, parametrised bandwidth throttle for the synthetic traffic bench. It keeps one Bresenham-style credit accumulator per request queue and grants a one-cycle `ready` pulse so that each queue's accepted traffic tracks its programmed percentage, weighted by burst length. It sits between the traffic generators and the AXI/DBB driver arbiter, replacing the single-accumulator throttle. It adds per-channel state, clamping, saturation, a bypass mode, per-channel reload and grant counters.

## Interface
- `NUM_CH`, default 4: number of independent channels (queues).
- `LOG2_CH`, default 2: width of `id`; must equal ceil(log2(NUM_CH)), minimum 1.
- `PERC_W`, default 8: width of each per-channel percentage field.
- `LEN_W`, default 4: width of the burst-length weight.
- `ACC_W`, default 16: signed accumulator width.
- `DENOM`, default 100: full-scale percentage value.
- `CNT_W`, default 16: width of each grant counter.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `bypass` in 1: 1 means grant without throttling; accumulators are untouched.
- `perc` in NUM_CH*PERC_W: packed per-channel target percentage; channel c is at bits [c*PERC_W +: PERC_W].
- `reload` in NUM_CH: per-channel pulse that reinitialises the accumulator from the current `perc`.
- `valid` in 1: request present.
- `id` in LOG2_CH: requesting channel.
- `len` in LEN_W: burst weight of the request.
- `ready` out 1: registered one-cycle grant pulse.
- `ready_id` out LOG2_CH: channel that was granted; meaningful only while `ready`=1.
- `grant_cnt` out NUM_CH*CNT_W: packed per-channel grant counters.

## Operation

**Per-channel quantities**
- Effective percentage: p_c = min(perc_c, DENOM).
- Initial value: init_c = 2*p_c − DENOM.

**Evaluation**
- An evaluation occurs in any cycle with `valid`=1, `ready`=0 and `id` < NUM_CH.
- `id` ≥ NUM_CH is ignored: no evaluation and no state change.
- Throttle mode (`bypass`=0), with channel c = `id` and accumulator d_c (signed):
  - If d_c > 0, grant: `ready`←1, `ready_id`←c, d_c ← sat(d_c + (2*p_c − 2*DENOM)*len).
  - Otherwise, deny: `ready`←0, d_c ← sat(d_c + 2*p_c).
- Bypass mode (`bypass`=1): every evaluation grants and no accumulator changes.
- A grant increments grant_cnt[c]. The counter wraps modulo 2^CNT_W.
- `len`=0 counts as a grant with zero accumulator debit.

**Arithmetic**
- Products and sums are computed at ACC_W+LEN_W+2 bits, signed.
- sat() clamps the result to the signed ACC_W range [−2^(ACC_W−1), 2^(ACC_W−1)−1]. It never wraps.

**Boundary behaviour**
- p=0: init = −DENOM and deny adds 0, so the channel never grants in throttle mode.
- p ≥ DENOM: the grant debit is 0 and init > 0, so the channel grants on every evaluation.
- In a cycle with `ready`=1: no evaluation, `ready`←0 next cycle, and accumulators hold.
- Idle channels and cycles with `valid`=0 hold all state.
- Changes to `perc` take effect at the next evaluation. The accumulator is not reinitialised unless `reload` is pulsed.
- `reload`[c] coinciding with an evaluation of c: reload wins. d_c←init_c, the cycle is treated as a deny with `ready`←0, and there is no counter increment.
- `reset` (including mid-operation) takes priority over everything else:
  - all d_c←init_c from the current `perc`;
  - `ready`=0, `ready_id`=0;
  - all `grant_cnt`=0.

## Timing
- The grant decision is registered. `ready` rises one cycle after the evaluating `valid` cycle.
- `ready` always lasts exactly one cycle.
- Maximum throughput is one grant every 2 cycles.
- The requester holds `valid`, `id` and `len` stable until it samples `ready`=1.
- `grant_cnt` updates in the same edge that raises `ready`.
- The cycle after `reset` deasserts is the first cycle that can evaluate.

## Structure
- Shared package `syn_tb_pkg`: DENOM default, the saturation helper function, and the channel-index type sized by LOG2_CH (consistent with `LOG2_Q`).
- Sub-module `throttle_acc`: one accumulator per channel, containing init, update, saturation and reload. It is instantiated NUM_CH times with a generate loop.
- Top level: id decode, the ready/ready_id registers, bypass handling and the grant counters.
- Target size is roughly 200–300 lines of RTL.

## Test plan
- **Reset:** assert `reset` 3 cycles with perc={4×50} → `ready`=0, `ready_id`=0, all `grant_cnt`=0; the first evaluation on ch0 is a deny (d0=0).
- **50 % pacing:** ch0 perc=50, len=1, `valid` held, re-asserted after each grant for 40 evaluations → evaluations alternate deny/grant, grant_cnt[0]=20, every `ready` pulse is 1 cycle.
- **Extremes and clamping:**
  - perc=100 → every evaluation grants;
  - perc=0 → 50 evaluations with no grant;
  - perc=200 → behaves identically to 100.
- **Channel independence and saturation:** ch1 perc=100, ch2 perc=0, interleaved ids → only ch1 grants; ch3 perc=10, len=15 with ACC_W=8 → d3 never wraps positive and the grant ratio stays low.
- **Bypass and reload:** `bypass`=1 on ch2 (perc=0) → grants every 2 cycles and d2 unchanged; `reload`[0] coinciding with a ch0 evaluation → no `ready`, d0=init.
- **Mid-operation reset:** `reset` during a `ready` pulse → `ready`=0 the next cycle, counters cleared, accumulators reinitialised.
